ahb_rom_ctrl: RTL and testbench

AHB_ROM_CTRL -- requirements
Module: ahb_rom_ctrl

---
 rtl/ahb_rom_ctrl.sv | 127 ++++++++++++
 tb/tb_ahb_rom_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_rom_ctrl.sv
// AHB-Lite read-only slave in front of a synchronous ROM, with an optional one-word read buffer.
// Misses take 2+WS data-phase cycles; buffer hits complete in one, writes answer with a two-cycle ERROR.
module ahb_rom_ctrl #(
  parameter int AW     = 13,
  parameter int WS     = 1,
  parameter int BUF_EN = 1
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic          HREADY,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [31:0]   HADDR,
  output logic          HREADYOUT,
  output logic [1:0]    HRESP,
  output logic [31:0]   HRDATA,
  input  logic [31:0]   ROMRDATA,
  output logic          ROMCS,
  output logic [AW-3:0] ROMADDR,
  input  logic          ROMINV
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_hit;
  logic          r_valid;
  logic          r_inv_seen;
  logic          r_hreadyout;
  logic          r_romcs;
  logic [1:0]    r_hresp;
  logic [AW-3:0] r_tag;
  logic [AW-3:0] r_romaddr;
  logic [31:0]   r_data;

  logic [AW-3:0] w_word;
  logic [AW-3:0] w_ntag;
  logic          w_accept;
  logic          w_load;
  logic          w_nvalid;
  logic          w_hit;
  logic          w_unused;

  assign w_word   = HADDR[AW-1:2];
  assign w_accept = HSEL & HREADY & HTRANS[1] & r_hreadyout;
  assign w_load   = (r_state == S_DATA);
  // Hit test looks at the buffer as it stands after this edge, so a read accepted in DATA can hit the word being loaded.
  assign w_nvalid = (BUF_EN != 0) && !ROMINV && (w_load ? !r_inv_seen : r_valid);
  assign w_ntag   = w_load ? r_romaddr : r_tag;
  assign w_hit    = !HWRITE && w_nvalid && (w_ntag == w_word);
  assign w_unused = &{1'b0, HADDR[31:AW], HADDR[1:0], HTRANS[0]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hit       <= 1'b0;
      r_valid     <= 1'b0;
      r_inv_seen  <= 1'b0;
      r_hreadyout <= 1'b1;
      r_romcs     <= 1'b0;
      r_hresp     <= 2'b00;
      r_tag       <= '0;
      r_romaddr   <= '0;
      r_data      <= '0;
    end else begin
      r_romcs    <= 1'b0;
      r_valid    <= w_nvalid;
      r_inv_seen <= r_inv_seen | ROMINV;
      if (w_load) begin
        r_tag  <= r_romaddr;
        r_data <= ROMRDATA;
      end
      case (r_state)
        S_REQ: begin
          r_cnt <= '0;
          if (WS == 0) begin
            r_state     <= S_DATA;
            r_hreadyout <= 1'b1;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'(WS - 1)) begin
            r_state     <= S_DATA;
            r_hreadyout <= 1'b1;
          end
        end
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
        end
        default: begin
          r_hit       <= 1'b0;
          r_hresp     <= 2'b00;
          r_state     <= S_IDLE;
          r_hreadyout <= 1'b1;
          if (w_accept) begin
            if (HWRITE) begin
              r_state     <= S_ERR1;
              r_hresp     <= 2'b01;
              r_hreadyout <= 1'b0;
            end else if (w_hit) begin
              r_hit <= 1'b1;
            end else begin
              r_state     <= S_REQ;
              r_romaddr   <= w_word;
              r_romcs     <= 1'b1;
              r_hreadyout <= 1'b0;
              r_inv_seen  <= ROMINV;
            end
          end
        end
      endcase
    end
  end

  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;
  assign ROMCS     = r_romcs;
  assign ROMADDR   = r_romaddr;
  assign HRDATA    = r_hit ? r_data : ROMRDATA;

endmodule

// File: tb/tb_ahb_rom_ctrl.sv
// Bench for ahb_rom_ctrl: instance 0 (WS=1) is exercised in depth against a transaction-level buffer model;
// instances with WS=0, WS=15 and BUF_EN=0 share the bus and are checked on a final pair of reads.
module tb_ahb_rom_ctrl;
  localparam int AW = 13;
  localparam int NW = 1 << (AW - 2);
  localparam int WS_L [4] = '{1, 0, 15, 1};
  localparam int BE_L [4] = '{1, 1, 1, 0};

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel, hready, hwrite, rominv;
  logic [1:0]  htrans;
  logic [31:0] haddr;

  logic        hro     [4];
  logic [1:0]  hresp   [4];
  logic [31:0] hrdata  [4];
  logic        romcs   [4];
  logic [10:0] romaddr [4];

  logic [31:0] rom [NW];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 hclk = ~hclk;

  for (genvar g = 0; g < 4; g++) begin : gd
    localparam int D = WS_L[g];
    logic [31:0] pipe [D+1];
    ahb_rom_ctrl #(.AW(AW), .WS(WS_L[g]), .BUF_EN(BE_L[g])) dut (
      .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel), .HREADY(hready), .HTRANS(htrans),
      .HWRITE(hwrite), .HADDR(haddr), .HREADYOUT(hro[g]), .HRESP(hresp[g]), .HRDATA(hrdata[g]),
      .ROMRDATA(pipe[D]), .ROMCS(romcs[g]), .ROMADDR(romaddr[g]), .ROMINV(rominv)
    );
    // ROM returns data WS+1 edges after the strobe cycle; junk otherwise.
    always @(posedge hclk) begin
      pipe[0] <= romcs[g] ? rom[romaddr[g]] : 32'hDEAD_BEEF;
      for (int i = 1; i <= D; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Buffer model: contents as they stand after the current cycle.
  bit          m_valid;
  logic [10:0] m_tag;
  logic [31:0] m_data;
  bit          ld_pend, ld_inv;
  logic [10:0] ld_tag;
  logic [31:0] ld_data;
  // Transfer in its data phase.
  bit          p_act, p_write, p_hit, p_inv;
  logic [10:0] p_word;
  logic [31:0] p_data;
  int          p_lat, last_lat, wait_inv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit sel, input bit rdy, input logic [1:0] trans, input bit wr,
                       input logic [10:0] word, input logic [31:0] hi, input bit inv);
    hsel = sel; hready = rdy; htrans = trans; hwrite = wr; rominv = inv;
    haddr = {hi[31:13], word, hi[1:0]};
    if (ld_pend) begin
      m_tag = ld_tag; m_data = ld_data; m_valid = (BE_L[0] != 0) && !ld_inv; ld_pend = 0;
    end
    if (inv) m_valid = 0;
    p_act  = sel && rdy && trans[1];
    p_write = wr; p_word = word; p_inv = inv;
    p_hit  = !wr && m_valid && (m_tag == word);
    p_data = p_hit ? m_data : rom[word];
    p_lat  = wr ? 2 : (p_hit ? 1 : 2 + WS_L[0]);
  endtask

  task automatic finish_xfer();
    int n;
    bit winv, miss;
    @(posedge hclk); #1;
    if (!p_act) begin
      chk("idle_ready", hro[0], 1'b1);
      chk("idle_resp", hresp[0], 2'b00);
      chk("idle_romcs", romcs[0], 1'b0);
      last_lat = 0;
      return;
    end
    miss = !p_write && !p_hit;
    n = 1;
    while (hro[0] !== 1'b1) begin
      chk("wait_romcs", romcs[0], miss && n == 1);
      if (miss && n == 1) chk("romaddr", romaddr[0], p_word);
      chk("wait_resp", hresp[0], p_write ? 2'b01 : 2'b00);
      if (n > p_lat) begin
        chk("lat_timeout", n, p_lat);
        p_act = 0;
        return;
      end
      hsel = 1'($urandom); hready = 1'($urandom); htrans = 2'($urandom);
      hwrite = 1'($urandom); haddr = $urandom;
      winv = (wait_inv == 1 && n == 2) || (wait_inv == 2 && $urandom_range(0, 5) == 0);
      rominv = winv;
      if (winv) begin p_inv = 1; m_valid = 0; end
      @(posedge hclk); #1;
      n++;
    end
    chk("done_romcs", romcs[0], 1'b0);
    chk("latency", n, p_lat);
    chk("done_resp", hresp[0], p_write ? 2'b01 : 2'b00);
    if (!p_write) chk("hrdata", hrdata[0], p_data);
    if (miss) begin
      ld_pend = 1; ld_tag = p_word; ld_data = rom[p_word]; ld_inv = p_inv;
    end
    last_lat = n;
    p_act = 0;
  endtask

  task automatic read(input logic [10:0] word);
    issue(1, 1, 2'b10, 0, word, 32'h0, 0);
    finish_xfer();
  endtask

  task automatic multi_read(input logic [10:0] word, input int pass);
    int low [4];
    int cs [4];
    bit done [4];
    logic [31:0] dat [4];
    bit hit;
    hsel = 1; hready = 1; htrans = 2'b10; hwrite = 0; rominv = 0;
    haddr = {19'h0, word, 2'b00};
    for (int g = 0; g < 4; g++) begin low[g] = 0; cs[g] = 0; done[g] = 0; dat[g] = '0; end
    for (int c = 0; c < 20; c++) begin
      @(posedge hclk); #1;
      hsel = 0; htrans = 2'b00;
      for (int g = 0; g < 4; g++) begin
        if (!done[g]) begin
          if (romcs[g]) cs[g]++;
          if (hro[g]) begin done[g] = 1; dat[g] = hrdata[g]; end
          else low[g]++;
        end
      end
    end
    for (int g = 0; g < 4; g++) begin
      hit = (pass == 2) && (BE_L[g] != 0);
      chk($sformatf("cfg%0d_low_p%0d", g, pass), low[g], hit ? 0 : WS_L[g] + 1);
      chk($sformatf("cfg%0d_romcs_p%0d", g, pass), cs[g], hit ? 0 : 1);
      chk($sformatf("cfg%0d_data_p%0d", g, pass), dat[g], rom[word]);
      chk($sformatf("cfg%0d_done_p%0d", g, pass), done[g], 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] w;
    for (int i = 0; i < NW; i++) rom[i] = $urandom;
    rom[4] = 32'hCAFE_0004;
    m_valid = 0; ld_pend = 0; p_act = 0; wait_inv = 0;
    hresetn = 0; hsel = 0; hready = 1; htrans = 2'b00; hwrite = 0; haddr = '0; rominv = 0;
    repeat (3) @(posedge hclk);
    #1;
    chk("rst_ready", hro[0], 1'b1);
    chk("rst_resp", hresp[0], 2'b00);
    chk("rst_romcs", romcs[0], 1'b0);
    chk("rst_romaddr", romaddr[0], 11'd0);
    hresetn = 1;

    // First read of word 4 is a miss, the back-to-back repeat hits.
    read(11'd4);
    chk("miss_lat", last_lat, 3);
    chk("miss_data", hrdata[0], 32'hCAFE_0004);
    read(11'd4);
    chk("hit_lat", last_lat, 1);
    chk("hit_data", hrdata[0], 32'hCAFE_0004);

    // Write gets ERR1/ERR2 and leaves the buffer alone.
    issue(1, 1, 2'b10, 1, 11'd8, 32'h0, 0);
    finish_xfer();
    chk("err_lat", last_lat, 2);
    chk("err_resp", hresp[0], 2'b01);
    read(11'd4);
    chk("hit_after_err", last_lat, 1);

    // Invalidate during the WAIT cycle: the loaded word is not kept.
    wait_inv = 1;
    read(11'd16);
    wait_inv = 0;
    read(11'd16);
    chk("inv_reread_lat", last_lat, 3);
    read(11'd16);
    chk("inv_third_lat", last_lat, 1);

    // Cycles that must not be accepted.
    issue(1, 1, 2'b00, 0, 11'd16, 32'h0, 0); finish_xfer();
    issue(1, 1, 2'b01, 0, 11'd16, 32'h0, 0); finish_xfer();
    issue(1, 0, 2'b10, 0, 11'd16, 32'h0, 0); finish_xfer();
    issue(0, 1, 2'b10, 1, 11'd16, 32'h0, 0); finish_xfer();

    // Reset dropped in the middle of a miss.
    read(11'd4);
    issue(1, 1, 2'b10, 0, 11'd32, 32'h0, 0);
    @(posedge hclk); #1;
    chk("pre_rst_romcs", romcs[0], 1'b1);
    @(posedge hclk); #2;
    hresetn = 0;
    #1;
    chk("async_rst_ready", hro[0], 1'b1);
    chk("async_rst_resp", hresp[0], 2'b00);
    chk("async_rst_romcs", romcs[0], 1'b0);
    chk("async_rst_romaddr", romaddr[0], 11'd0);
    @(posedge hclk); #1;
    hresetn = 1;
    p_act = 0; ld_pend = 0; m_valid = 0;
    read(11'd32);
    chk("post_rst_lat", last_lat, 3);
    read(11'd4);
    chk("post_rst_buf_cleared", last_lat, 3);

    // Randomized traffic on a small address set so hits and misses mix.
    wait_inv = 2;
    for (int t = 0; t < 400; t++) begin
      w = 11'($urandom_range(0, 5)) + 11'd100;
      issue($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
            ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3)),
            $urandom_range(0, 6) == 0, w, $urandom, $urandom_range(0, 9) == 0);
      finish_xfer();
    end
    wait_inv = 0;

    // Let every configuration drain, flush all buffers, then read the same word twice.
    for (int c = 0; c < 20; c++) begin
      issue(0, 1, 2'b00, 0, 11'd0, 32'h0, c == 19);
      finish_xfer();
    end
    multi_read(11'h1A5, 1);
    multi_read(11'h1A5, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
